// File: rtl/gerenciador_vidas_if.sv
// gerenciador_vidas_if: request/status bundle between the game datapath and
// the life manager.
//   perde_vida   : lose-one-life request, one cycle per request
//   ganha_vida   : gain-one-life request, one cycle per request
//   vidas        : current life count (LARGURA bits)
//   invulneravel : post-loss invulnerability window active
//   fim_jogo     : game over, latched until reset
//   perda_pulso  : one-cycle pulse for each accepted loss
// master drives the requests and reads the status. slave is the life manager.
interface gerenciador_vidas_if #(
  parameter int LARGURA = 3
);
  logic               perde_vida;
  logic               ganha_vida;
  logic [LARGURA-1:0] vidas;
  logic               invulneravel;
  logic               fim_jogo;
  logic               perda_pulso;

  modport master (
    output perde_vida, ganha_vida,
    input  vidas, invulneravel, fim_jogo, perda_pulso
  );

  modport slave (
    input  perde_vida, ganha_vida,
    output vidas, invulneravel, fim_jogo, perda_pulso
  );
endinterface

// File: rtl/gerenciador_vidas.sv
// gerenciador_vidas: player life manager.
// It keeps a life count that saturates at VIDAS_MAX.
// After each loss it opens an invulnerability window that lasts INVULN_CICLOS
// cycles. It latches game-over when the count reaches zero.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : gerenciador_vidas_if.slave (requests in, registered status out)
// Build option:
//   GANHO_VIDA_EN - when defined, ganha_vida adds a life.
//                   When undefined, ganha_vida is ignored and no gain logic
//                   is built.
// States: JOGANDO (normal play), INVULNERAVEL (losses ignored), FIM (absorbing).
module gerenciador_vidas #(
  parameter int LARGURA        = 3,
  parameter int VIDAS_INICIAIS = 3,
  parameter int VIDAS_MAX      = 7,
  parameter int INVULN_CICLOS  = 4
) (
  input logic                  clock,
  input logic                  reset,
  gerenciador_vidas_if.slave   bus
);

  // The timer counts INVULN_CICLOS-1 down to 0. It keeps at least one bit
  // even when the window is disabled.
  localparam int TW = (INVULN_CICLOS > 0) ? $clog2(INVULN_CICLOS + 1) : 1;
  localparam logic [TW-1:0]      TCARGA = TW'((INVULN_CICLOS > 0) ? INVULN_CICLOS - 1 : 0);
  localparam logic [LARGURA-1:0] VINI   = LARGURA'(VIDAS_INICIAIS);
  localparam logic [LARGURA-1:0] VUM    = LARGURA'(1);

  typedef enum logic [1:0] {
    JOGANDO      = 2'd0,
    INVULNERAVEL = 2'd1,
    FIM          = 2'd2
  } estado_t;

  estado_t            estado;
  logic [TW-1:0]      timer;
  logic [LARGURA-1:0] vidas_q;
  logic               inv_q;
  logic               fim_q;
  logic               pulso_q;

  // ganho is the effective gain request.
  // vidas_inc is the saturated count after a gain.
  logic               ganho;
  logic [LARGURA-1:0] vidas_inc;

`ifdef GANHO_VIDA_EN
  localparam logic [LARGURA-1:0] VMAX = LARGURA'(VIDAS_MAX);
  assign ganho     = bus.ganha_vida;
  assign vidas_inc = (vidas_q >= VMAX) ? VMAX : vidas_q + VUM;
`else
  // Gain is disabled, so the count after a "gain" is just the current count.
  assign ganho     = 1'b0;
  assign vidas_inc = vidas_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      estado  <= JOGANDO;
      timer   <= '0;
      vidas_q <= VINI;
      inv_q   <= 1'b0;
      fim_q   <= 1'b0;
      pulso_q <= 1'b0;
    end else begin
      pulso_q <= 1'b0;
      case (estado)
        JOGANDO: begin
          // A loss and a gain in the same cycle cancel each other.
          if (bus.perde_vida && !ganho) begin
            pulso_q <= 1'b1;
            if (vidas_q == VUM) begin
              vidas_q <= '0;
              estado  <= FIM;
              fim_q   <= 1'b1;
            end else begin
              vidas_q <= vidas_q - VUM;
              if (INVULN_CICLOS > 0) begin
                estado <= INVULNERAVEL;
                inv_q  <= 1'b1;
                timer  <= TCARGA;
              end
            end
          end else if (ganho && !bus.perde_vida) begin
            vidas_q <= vidas_inc;
          end
        end

        INVULNERAVEL: begin
          // Losses are ignored here. A gain still counts.
          if (ganho) vidas_q <= vidas_inc;
          if (timer == '0) begin
            estado <= JOGANDO;
            inv_q  <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        FIM: begin
          // Absorbing state: hold until reset.
          vidas_q <= '0;
          fim_q   <= 1'b1;
          inv_q   <= 1'b0;
        end

        default: begin
          estado <= JOGANDO;
          inv_q  <= 1'b0;
          fim_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.vidas        = vidas_q;
  assign bus.invulneravel = inv_q;
  assign bus.fim_jogo     = fim_q;
  assign bus.perda_pulso  = pulso_q;

endmodule

// File: tb/tb_gerenciador_vidas.sv
// tb_gerenciador_vidas: directed bench for gerenciador_vidas with the default
// parameters (LARGURA=3, VIDAS_INICIAIS=3, VIDAS_MAX=7, INVULN_CICLOS=4).
// The gain checks follow GANHO_VIDA_EN, so the bench matches the RTL build.
module tb_gerenciador_vidas;
  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  gerenciador_vidas_if #(.LARGURA(3)) bus ();

  gerenciador_vidas #(
    .LARGURA(3), .VIDAS_INICIAIS(3), .VIDAS_MAX(7), .INVULN_CICLOS(4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Step one edge, then settle before sampling.
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input int v, input int inv, input int fim, input int p);
    chk({tag, ".vidas"}, int'(bus.vidas), v);
    chk({tag, ".inv"},   int'(bus.invulneravel), inv);
    chk({tag, ".fim"},   int'(bus.fim_jogo), fim);
    chk({tag, ".pulso"}, int'(bus.perda_pulso), p);
  endtask

  initial begin
    reset = 1'b1;
    bus.perde_vida = 1'b0;
    bus.ganha_vida = 1'b0;
    tick; tick;
    reset = 1'b0;
    tick;
    chk_all("rst", 3, 0, 0, 0);

    // Single loss, then a 4-cycle window.
    bus.perde_vida = 1'b1;
    tick;
    bus.perde_vida = 1'b0;
    chk_all("loss1", 2, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_all("win", 2, 1, 0, 0);
    end
    tick;
    chk_all("win_end", 2, 0, 0, 0);

    // Hold the loss request from 3 lives: pulses at 0, 5 and 10.
    reset = 1'b1;
    tick;
    reset = 1'b0;
    bus.perde_vida = 1'b1;
    for (int i = 0; i < 20; i++) begin
      int ev, ei, ef, ep;
      tick;
      ev = (i < 5) ? 2 : (i < 10) ? 1 : 0;
      ei = ((i <= 3) || (i >= 5 && i <= 8)) ? 1 : 0;
      ef = (i >= 10) ? 1 : 0;
      ep = (i == 0 || i == 5 || i == 10) ? 1 : 0;
      chk_all($sformatf("hold%0d", i), ev, ei, ef, ep);
    end

    // FIM ignores every request.
    bus.ganha_vida = 1'b1;
    tick; tick;
    chk_all("fim_abs", 0, 0, 1, 0);
    bus.ganha_vida = 1'b0;

    // Reset out of FIM, with a loss request pending.
    reset = 1'b1;
    tick;
    chk_all("rst_fim", 3, 0, 0, 0);
    reset = 1'b0;

    // Reset mid-window, when the timer is 2.
    tick;
    bus.perde_vida = 1'b0;
    chk_all("pre_win", 2, 1, 0, 1);
    tick;
    chk("mid_win.inv", int'(bus.invulneravel), 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk_all("rst_win", 3, 0, 0, 0);

`ifdef GANHO_VIDA_EN
    // Gains saturate at 7.
    for (int k = 1; k <= 6; k++) begin
      bus.ganha_vida = 1'b1;
      tick;
      chk($sformatf("gain%0d", k), int'(bus.vidas), (3 + k > 7) ? 7 : 3 + k);
    end
    // A loss and a gain in the same cycle cancel.
    bus.perde_vida = 1'b1;
    tick;
    chk_all("cancel", 7, 0, 0, 0);
    bus.ganha_vida = 1'b0;
    tick;
    bus.perde_vida = 1'b0;
    chk_all("loss_7", 6, 1, 0, 1);
    // A gain still counts inside the window.
    bus.ganha_vida = 1'b1;
    tick;
    bus.ganha_vida = 1'b0;
    chk_all("gain_inv", 7, 1, 0, 0);
`else
    // Gain requests are ignored.
    bus.ganha_vida = 1'b1;
    tick;
    chk("nogain1", int'(bus.vidas), 3);
    tick;
    chk("nogain2", int'(bus.vidas), 3);
    // A loss and a gain together act as a plain loss.
    bus.perde_vida = 1'b1;
    tick;
    bus.perde_vida = 1'b0;
    bus.ganha_vida = 1'b0;
    chk_all("pg_loss", 2, 1, 0, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
